// File: rtl/mem_bram_fifo_ctrl_if.sv
// mem_bram_fifo_ctrl_if: write stream, read stream, BRAM ports and status of the BRAM FIFO sequencer
interface mem_bram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 12,
  parameter int BRAM_DEPTH = 16384
);
  localparam int AW = $clog2(BRAM_DEPTH);
  logic                  i_flush;
  logic [DATA_WIDTH-1:0] i_s_data;
  logic                  i_s_valid;
  logic                  o_s_ready;
  logic [DATA_WIDTH-1:0] o_m_data;
  logic                  o_m_valid;
  logic                  i_m_ready;
  logic                  o_bram_wportEn;
  logic                  o_bram_wr;
  logic [AW-1:0]         o_bram_waddr;
  logic [DATA_WIDTH-1:0] o_bram_wdata;
  logic                  o_bram_rportEn;
  logic [AW-1:0]         o_bram_raddr;
  logic [DATA_WIDTH-1:0] i_bram_rdata;
  logic [AW:0]           o_level;
  logic                  o_full;
  logic                  o_empty;
  modport slave (
    input  i_flush, i_s_data, i_s_valid, i_m_ready, i_bram_rdata,
    output o_s_ready, o_m_data, o_m_valid, o_bram_wportEn, o_bram_wr, o_bram_waddr,
           o_bram_wdata, o_bram_rportEn, o_bram_raddr, o_level, o_full, o_empty
  );
  modport master (
    output i_flush, i_s_data, i_s_valid, i_m_ready, i_bram_rdata,
    input  o_s_ready, o_m_data, o_m_valid, o_bram_wportEn, o_bram_wr, o_bram_waddr,
           o_bram_wdata, o_bram_rportEn, o_bram_raddr, o_level, o_full, o_empty
  );
endinterface

// File: rtl/mem_bram_fifo_ctrl.sv
// mem_bram_fifo_ctrl: circular-pointer FIFO over a 1-cycle-latency BRAM with a 2-entry FWFT output buffer
module mem_bram_fifo_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int BRAM_DEPTH = 16384
) (
  input logic i_clk,
  input logic i_rstn,
  mem_bram_fifo_ctrl_if.slave bus
);
  localparam int AW = $clog2(BRAM_DEPTH);
  localparam logic [AW-1:0] LAST = AW'(BRAM_DEPTH - 1);
  localparam logic [AW:0] FULLV = (AW + 1)'(BRAM_DEPTH);
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]           level_q, level_d;
  logic                  inflight_q, inflight_d, s_ready_q, s_ready_d;
  logic [1:0]            occ_q, occ_d, widx;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic                  wr_acc, rd_issue, pop, push;
  always_comb begin
    wr_acc     = bus.i_s_valid & s_ready_q & ~bus.i_flush;
    pop        = (occ_q != 2'd0) & bus.i_m_ready;
    // only issue if the word returning next edge has a slot even without a further pop
    rd_issue   = (level_q != '0) & ~bus.i_flush &
                 ({1'b0, occ_q} + {2'b0, inflight_q} <= 3'd1 + {2'b0, pop});
    push       = inflight_q & ~bus.i_flush;
    widx       = occ_q - {1'b0, pop};
    wptr_d     = bus.i_flush ? '0 : wr_acc ? (wptr_q == LAST ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d     = bus.i_flush ? '0 : rd_issue ? (rptr_q == LAST ? '0 : rptr_q + 1'b1) : rptr_q;
    level_d    = bus.i_flush ? '0 : level_q + (AW + 1)'(wr_acc) - (AW + 1)'(rd_issue);
    inflight_d = rd_issue;
    occ_d      = bus.i_flush ? 2'd0 : occ_q + {1'b0, push} - {1'b0, pop};
    buf0_d     = (push && widx == 2'd0) ? bus.i_bram_rdata : pop ? buf1_q : buf0_q;
    buf1_d     = (push && widx == 2'd1) ? bus.i_bram_rdata : buf1_q;
    s_ready_d  = level_d != FULLV;
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      s_ready_q  <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      s_ready_q  <= s_ready_d;
    end
  end
  assign bus.o_s_ready      = s_ready_q & ~bus.i_flush;
  assign bus.o_bram_wportEn = wr_acc;
  assign bus.o_bram_wr      = wr_acc;
  assign bus.o_bram_waddr   = wptr_q;
  assign bus.o_bram_wdata   = bus.i_s_data;
  assign bus.o_bram_rportEn = rd_issue;
  assign bus.o_bram_raddr   = rptr_q;
  assign bus.o_m_data       = buf0_q;
  assign bus.o_m_valid      = occ_q != 2'd0;
  assign bus.o_level        = level_q;
  assign bus.o_full         = level_q == FULLV;
  assign bus.o_empty        = (level_q == '0) & ~inflight_q & (occ_q == 2'd0);
endmodule
